instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage that supplies instruction words and pre-split decode fields (opcode, funct3, funct7) to the control/decode logic.
- Consumes branch redirects produced downstream from control's branch/zero resolution.
- Issues in-order requests to instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned words in a small FIFO ahead of a valid/ready decode handshake.

Parameters:
- WIDTH, 64, PC/address width in bits.
- RESET_PC, 64'h0, PC fetched first after reset.
- BUF_DEPTH, 4, instruction FIFO entries; power of two, >=2.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  WIDTH  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; in order, latency >=1, no backpressure.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  taken branch/jump; flush and refetch.
- redirect_pc  input  WIDTH  redirect target.
- dec_valid  output  1  FIFO head valid.
- dec_ready  input  1  decode consumes head.
- dec_instr  output  32  head instruction.
- dec_pc  output  WIDTH  PC of head instruction.
- dec_opcode  output  opcode_t  dec_instr[6:0].
- dec_funct3  output  3  dec_instr[14:12].
- dec_funct7  output  7  dec_instr[31:25].

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; imem_req_valid=0; dec_valid=0; dec_* data 0.
- Request issue:
  - imem_req_valid=1 iff discard==0 and outstanding + occupancy - pop < BUF_DEPTH, where pop = dec_valid & dec_ready.
  - imem_req_addr=fetch_pc.
  - On acceptance (valid & ready): fetch_pc += 4 (mod 2^WIDTH, wraps silently); outstanding++.
  - Requests are never withdrawn except by redirect.
- Credit rule guarantees every non-discarded response has a free FIFO slot; no response is ever dropped for lack of space.
- Response:
  - If discard>0: drop the word; discard--; outstanding--.
  - Else: push {word, pc} into the FIFO; outstanding--.
  - Entry PC comes from a parallel PC queue, or from rsp_pc, which starts at the request base and increments per kept response.
- Decode side:
  - dec_* driven from FIFO head registers.
  - A response arriving at cycle N gives dec_valid at N+1 at the earliest (no combinational bypass).
  - Pop on dec_valid & dec_ready.
  - Simultaneous push and pop at full or empty is legal; occupancy unchanged.
- Redirect, cycle R (highest priority):
  - FIFO flushed; dec_valid=0 at R+1.
  - Any pop in cycle R is still honoured by the consumer, but the FIFO is flushed regardless.
  - discard <= outstanding at end of R, counting any request accepted in R and excluding any response consumed in R. The response arriving in R is dropped.
  - fetch_pc <= redirect_pc; first new request presented no earlier than R+1 and only once discard==0.
  - Back-to-back redirects: the last one wins; discard accumulates.
- Throughput: with 1-cycle memory latency and BUF_DEPTH>=4, sustains one instruction per cycle.
- Reset mid-operation: all state cleared immediately. In-flight memory responses after reset release are outside the protocol; memory must also be reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misaligned and suppresses all requests.
  - The flag holds until the next aligned redirect, which clears it and resumes fetch.
- Disabled: redirect_pc[1:0] forced to 2'b00; the port is absent.

Decomposition:
- Package common:
  - opcode_t (shared with control).
  - INSTR_W=32 and field slice constants: OPCODE_LSB/MSB, FUNCT3_LSB/MSB, FUNCT7_LSB/MSB.
  - fetch_entry_t struct {instr, pc}.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush, full/empty and count outputs, registered head.

Test Plan:
- Reset release, RESET_PC=0x1000, memory latency 1, dec_ready=1 -> addrs 0x1000, 0x1004, 0x1008… one per cycle; first dec_valid 2 cycles after first accept, dec_pc=0x1000; 8 instrs in 8 consecutive cycles after fill.
- dec_ready=0, BUF_DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; FIFO holds 0x1000–0x100C; raising dec_ready resumes in order with no loss or duplication.
- Memory latency 3, redirect_pc=0x2000 with 2 outstanding -> both stale responses dropped; next dec_pc=0x2000; stale words never reach dec_valid.
- Redirect in the same cycle as a request accept and a response -> discard equals the accepted-but-unreturned count; FIFO empty next cycle; first fetch 0x2000.
- Instr 0x00A302B3 -> dec_opcode=7'h33, dec_funct3=3'h0, dec_funct7=7'h00; instr 0x40A302B3 -> dec_funct7=7'h20.
- With FETCH_MISALIGN_TRAP_EN: redirect 0x2002 -> fetch_misaligned=1, no requests for 20 cycles; redirect 0x3000 -> flag 0, fetch at 0x3000.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch/decode types, field slices and fetch FIFO entry
package instr_fetch_pkg;

  localparam int INSTR_W    = 32;
  localparam int PC_W       = 64;
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_IMM    = 7'h13,
    OP_AUIPC  = 7'h17,
    OP_STORE  = 7'h23,
    OP_REG    = 7'h33,
    OP_LUI    = 7'h37,
    OP_BRANCH = 7'h63,
    OP_JALR   = 7'h67,
    OP_JAL    = 7'h6F,
    OP_SYSTEM = 7'h73
  } opcode_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
    return opcode_t'(instr[OPCODE_MSB:OPCODE_LSB]);
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - fetch_fifo: synchronous FIFO of fetch entries with flush and registered head
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with credit-based issue and redirect flush
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               BUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [WIDTH-1:0]   imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [WIDTH-1:0]   redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [31:0]        dec_instr,
  output logic [WIDTH-1:0]   dec_pc,
  output opcode_t            dec_opcode,
  output logic [2:0]         dec_funct3,
  output logic [6:0]         dec_funct7
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               fetch_misaligned
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_pc;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d, fifo_count;
  logic [CNT_W:0]   credits_used;
  logic             started_q, block_fetch;
  logic             fifo_full, fifo_empty, req_fire, pop, keep;
  fetch_entry_t     push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q, misaligned_d;

  assign target_pc        = redirect_pc;
  assign block_fetch      = misaligned_q;
  assign fetch_misaligned = misaligned_q;

  always_comb begin
    misaligned_d = misaligned_q;
    if (redirect_valid) misaligned_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
`else
  assign target_pc   = redirect_pc & ~WIDTH'(3);
  assign block_fetch = 1'b0;
`endif

  // Every in-flight request owns a FIFO slot, so kept responses always fit.
  assign pop            = dec_valid & dec_ready;
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
  assign imem_req_valid = started_q & (discard_q == '0) & ~block_fetch &
                          (credits_used < (CNT_W+1)'(BUF_DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign keep           = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    if (req_fire) fetch_pc_d = fetch_pc_q + WIDTH'(4);
    if (keep)     rsp_pc_d   = rsp_pc_q + WIDTH'(4);
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      discard_d  = outstanding_d;
    end else if (imem_rsp_valid && discard_q != '0) begin
      discard_d = discard_q - CNT_W'(1);
    end
    push_entry.instr = imem_rsp_data;
    push_entry.pc    = PC_W'(rsp_pc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      started_q     <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      started_q     <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep & (~fifo_full | pop)),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign dec_valid  = ~fifo_empty;
  assign dec_instr  = head.instr;
  assign dec_pc     = head.pc[WIDTH-1:0];
  assign dec_opcode = instr_opcode(head.instr);
  assign dec_funct3 = head.instr[FUNCT3_MSB:FUNCT3_LSB];
  assign dec_funct7 = head.instr[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with an epoch-tagged fetch model
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr;
  logic [63:0] dec_pc;
  opcode_t     dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  instr_fetch #(.WIDTH(64), .RESET_PC(64'h1000), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_funct3(dec_funct3), .dec_funct7(dec_funct7)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; int tag; int due; } mreq_t;
  typedef struct { logic [31:0] instr; logic [63:0] pc; } ment_t;
  typedef struct { logic [63:0] addr; int cyc; } acc_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; logic [6:0] op; logic [2:0] f3; logic [6:0] f7; int cyc; } pop_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, lat = 1, epoch = 0;
  logic chk_en = 1'b0, mis_m = 1'b0;
  logic [63:0] npc;
  mreq_t mq[$];
  ment_t fq[$];
  acc_t  acc_log[$];
  pop_t  pop_log[$];
  mreq_t cur;
  logic  cur_v = 1'b0;
  logic  exp_rv, exp_dv;
  logic [63:0] exp_addr, exp_pc;
  logic [31:0] exp_instr;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mem_word(logic [63:0] a);
    if (a == 64'h4000) return 32'h00A302B3;
    if (a == 64'h4004) return 32'h40A302B3;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Drive one clock: memory response, expectations, then the model's state change.
  task automatic step();
    int   inflight;
    logic stale, pop, acc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      cur = mq.pop_front();
      cur_v = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(cur.addr);
    end else begin
      cur_v = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    inflight = mq.size() + int'(cur_v);
    stale = cur_v && cur.tag != epoch;
    foreach (mq[i]) if (mq[i].tag != epoch) stale = 1'b1;
    exp_dv    = fq.size() > 0;
    exp_instr = exp_dv ? fq[0].instr : 32'h0;
    exp_pc    = exp_dv ? fq[0].pc : 64'h0;
    pop       = exp_dv && dec_ready;
    exp_rv    = !stale && !mis_m && (inflight + fq.size() - int'(pop) < DEPTH);
    exp_addr  = npc;
    @(negedge clk);
    #1;
    acc = exp_rv && imem_req_ready;
    if (acc) begin
      mq.push_back('{addr: npc, tag: epoch, due: cyc + lat});
      npc = npc + 64'd4;
    end
    if (redirect_valid) begin
      epoch++;
      fq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      npc   = redirect_pc;
      mis_m = redirect_pc[1:0] != 2'b00;
`else
      npc   = {redirect_pc[63:2], 2'b00};
`endif
    end else if (pop) begin
      void'(fq.pop_front());
    end
    if (cur_v && cur.tag == epoch) fq.push_back('{instr: mem_word(cur.addr), pc: cur.addr});
    cyc++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, exp_addr);
      chk("dec_valid", 64'(dec_valid), 64'(exp_dv));
      if (exp_dv) begin
        chk("dec_pc", dec_pc, exp_pc);
        chk("dec_instr", 64'(dec_instr), 64'(exp_instr));
        chk("dec_opcode", 64'(dec_opcode), 64'(exp_instr[6:0]));
        chk("dec_funct3", 64'(dec_funct3), 64'(exp_instr[14:12]));
        chk("dec_funct7", 64'(dec_funct7), 64'(exp_instr[31:25]));
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fetch_misaligned", 64'(fetch_misaligned), 64'(mis_m));
`endif
      if (imem_req_valid && imem_req_ready) acc_log.push_back('{addr: imem_req_addr, cyc: cyc});
      if (dec_valid && dec_ready)
        pop_log.push_back('{pc: dec_pc, instr: dec_instr, op: dec_opcode, f3: dec_funct3, f7: dec_funct7, cyc: cyc});
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    chk_en = 1'b0;
    imem_req_ready = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    mq.delete(); fq.delete(); acc_log.delete(); pop_log.delete();
    cur_v = 1'b0; epoch = 0; mis_m = 1'b0; npc = 64'h1000;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_dec_valid", 64'(dec_valid), 64'h0);
    chk("rst_dec_instr", 64'(dec_instr), 64'h0);
    chk("rst_dec_pc", dec_pc, 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misaligned", 64'(fetch_misaligned), 64'h0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk_en = 1'b1;
  endtask

  task automatic redirect(logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int rcyc, n_stale;
    logic [7:0] rdy_pat = 8'b1011_0110;
    @(posedge clk);
    #1;

    // streaming from reset, latency 1
    lat = 1;
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (14) step();
    if (acc_log.size() >= 3 && pop_log.size() >= 8) begin
      chk("t1_addr0", acc_log[0].addr, 64'h1000);
      chk("t1_addr1", acc_log[1].addr, 64'h1004);
      chk("t1_addr2", acc_log[2].addr, 64'h1008);
      chk("t1_first_dec_lat", 64'(pop_log[0].cyc - acc_log[0].cyc), 64'd2);
      chk("t1_first_dec_pc", pop_log[0].pc, 64'h1000);
      chk("t1_8_in_8", 64'(pop_log[7].cyc - pop_log[0].cyc), 64'd7);
    end else chk("t1_log_size", 64'(pop_log.size()), 64'd8);

    // decode stalled: credits stop at 4
    do_reset();
    imem_req_ready = 1'b1;
    repeat (10) step();
    chk("t2_accepts", 64'(acc_log.size()), 64'd4);
    if (acc_log.size() == 4) chk("t2_last_addr", acc_log[3].addr, 64'h100C);
    chk("t2_head_pc", dec_pc, 64'h1000);
    dec_ready = 1'b1;
    repeat (12) step();
    for (int i = 0; i < 8; i++)
      if (i < pop_log.size()) chk("t2_order", pop_log[i].pc, 64'h1000 + 64'(4 * i));
      else chk("t2_pop_missing", 64'(pop_log.size()), 64'd8);

    // decode fields through a redirect
    pop_log.delete();
    redirect(64'h4000);
    pop_log.delete();
    repeat (10) step();
    if (pop_log.size() >= 2) begin
      chk("t5_pc", pop_log[0].pc, 64'h4000);
      chk("t5_op", 64'(pop_log[0].op), 64'h33);
      chk("t5_f3", 64'(pop_log[0].f3), 64'h0);
      chk("t5_f7a", 64'(pop_log[0].f7), 64'h00);
      chk("t5_f7b", 64'(pop_log[1].f7), 64'h20);
    end else chk("t5_pops", 64'(pop_log.size()), 64'd2);

    // latency 3, redirect with two requests outstanding
    lat = 3;
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (2) step();
    imem_req_ready = 1'b0;
    redirect(64'h2000);
    imem_req_ready = 1'b1;
    acc_log.delete(); pop_log.delete();
    repeat (16) step();
    n_stale = 0;
    foreach (pop_log[i]) if (pop_log[i].pc < 64'h2000) n_stale++;
    chk("t3_stale_pops", 64'(n_stale), 64'd0);
    if (pop_log.size() > 0 && acc_log.size() > 0) begin
      chk("t3_first_pc", pop_log[0].pc, 64'h2000);
      chk("t3_first_addr", acc_log[0].addr, 64'h2000);
    end else chk("t3_pops", 64'(pop_log.size()), 64'd1);

    // redirect together with an accept and a response
    lat = 1;
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (8) step();
    rcyc = cyc;
    redirect(64'h2000);
    acc_log.delete();
    chk("t4_dec_flushed", 64'(dec_valid), 64'h0);
    chk("t4_req_held", 64'(imem_req_valid), 64'h0);
    repeat (4) step();
    if (acc_log.size() > 0) begin
      chk("t4_first_addr", acc_log[0].addr, 64'h2000);
      chk("t4_first_cyc", 64'(acc_log[0].cyc - rcyc), 64'd2);
    end else chk("t4_accepts", 64'(acc_log.size()), 64'd1);

    // mixed backpressure, latency 2, back-to-back redirects
    lat = 2;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      dec_ready      = rdy_pat[i % 8];
      imem_req_ready = rdy_pat[(i + 3) % 8];
      if (i == 15) begin
        redirect_valid = 1'b1; redirect_pc = 64'h5000;
      end else if (i == 16) begin
        redirect_valid = 1'b1; redirect_pc = 64'h6001;
      end else redirect_valid = 1'b0;
      if (i == 17) pop_log.delete();
      step();
    end
    redirect_valid = 1'b0;
    if (pop_log.size() > 0) chk("t6_last_wins", pop_log[0].pc, 64'h6000);
    else chk("t6_pops", 64'(pop_log.size()), 64'd1);

`ifdef FETCH_MISALIGN_TRAP_EN
    lat = 1;
    do_reset();
    imem_req_ready = 1'b1; dec_ready = 1'b1;
    repeat (4) step();
    redirect(64'h2002);
    chk("t7_flag_set", 64'(fetch_misaligned), 64'h1);
    acc_log.delete();
    repeat (20) step();
    chk("t7_no_requests", 64'(acc_log.size()), 64'd0);
    redirect(64'h3000);
    chk("t7_flag_clear", 64'(fetch_misaligned), 64'h0);
    acc_log.delete();
    repeat (5) step();
    if (acc_log.size() > 0) chk("t7_resume_addr", acc_log[0].addr, 64'h3000);
    else chk("t7_resume", 64'(acc_log.size()), 64'd1);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
